state_dump_unit: RTL and testbench

//  Hardware successor to the bench-side register/memory print loop: on a start pulse it stalls the core,

---
 rtl/state_dump_unit.sv | 208 ++++++++++++++++++++
 tb/tb_state_dump_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/state_dump_unit.sv
// -----------------------------------------------------------------------------
// state_dump_unit
//
// Purpose:
//   On a start pulse, stalls the core and streams its architectural state out
//   over a valid/ready port. Registers go first (ascending index), followed by
//   a programmable data-memory window (ascending address). This unit borrows
//   the register-bank and data-memory read ports while the core is halted.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   start      dump request, sampled only while idle
//   mem_base   first memory word address (latched on start)
//   mem_count  number of memory words to dump, 0 = registers only (latched)
//   cpu_halt   stall request to the core, high while busy
//   rf_addr    register read address (combinational read, data same cycle)
//   rf_data    register read data
//   mem_addr   memory read address (combinational read, data same cycle)
//   mem_data   memory read data
//   out_valid  output beat valid
//   out_ready  sink accepts the beat when out_valid & out_ready at the edge
//   out_data   dumped word
//   out_tag    0 = register beat, 1 = memory beat
//   out_index  register index, or memory word address
//   busy       high from the accepted start until the DONE state exits
//   done       one-cycle pulse after the last beat is accepted
// -----------------------------------------------------------------------------
module state_dump_unit #(
    parameter int DATA_W  = 32,
    parameter int NREGS   = 32,
    parameter int RF_AW   = 5,
    parameter int MEM_AW  = 10,
    parameter int SKIP_X0 = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [MEM_AW-1:0] mem_base,
    input  logic [MEM_AW:0]   mem_count,
    output logic              cpu_halt,
    output logic [RF_AW-1:0]  rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_tag,
    output logic [MEM_AW-1:0] out_index,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REGS,
        S_MEM,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [RF_AW-1:0] FIRST_REG = RF_AW'(SKIP_X0);
    localparam logic [RF_AW-1:0] LAST_REG  = RF_AW'(NREGS - 1);
    localparam logic [RF_AW-1:0] IDX_ONE   = RF_AW'(1);
    localparam logic [MEM_AW:0]  J_ONE     = (MEM_AW + 1)'(1);

    state_t              state_q,  state_d;
    logic [MEM_AW-1:0]   base_q,   base_d;
    logic [MEM_AW:0]     count_q,  count_d;
    logic [RF_AW-1:0]    idx_q,    idx_d;
    logic [MEM_AW:0]     j_q,      j_d;
    logic                valid_q,  valid_d;
    logic [DATA_W-1:0]   data_q,   data_d;
    logic                tag_q,    tag_d;
    logic [MEM_AW-1:0]   index_q,  index_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;

    logic [MEM_AW-1:0]   cur_mem_addr;
    logic                load_ok;

    // Address wraps modulo 2**MEM_AW by truncation of the sum.
    assign cur_mem_addr = base_q + j_q[MEM_AW-1:0];

    // The output register is free when empty or being drained this edge.
    assign load_ok = !valid_q || out_ready;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        count_d = count_q;
        idx_d   = idx_q;
        j_d     = j_q;
        valid_d = valid_q;
        data_d  = data_q;
        tag_d   = tag_q;
        index_d = index_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REGS;
                    busy_d  = 1'b1;
                    base_d  = mem_base;
                    count_d = mem_count;
                    idx_d   = FIRST_REG;
                    j_d     = '0;
                end
            end

            S_REGS: begin
                if (load_ok) begin
                    valid_d = 1'b1;
                    data_d  = rf_data;
                    tag_d   = 1'b0;
                    index_d = MEM_AW'(idx_q);
                    if (idx_q == LAST_REG) begin
                        // Go straight to memory so there is no bubble between phases.
                        state_d = (count_q != '0) ? S_MEM : S_WAIT;
                        j_d     = '0;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end

            S_MEM: begin
                if (load_ok) begin
                    valid_d = 1'b1;
                    data_d  = mem_data;
                    tag_d   = 1'b1;
                    index_d = cur_mem_addr;
                    if (j_q + J_ONE == count_q) begin
                        state_d = S_WAIT;
                    end else begin
                        j_d = j_q + J_ONE;
                    end
                end
            end

            S_WAIT: begin
                // Final beat is held until the sink takes it.
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                idx_d   = '0;
                j_d     = '0;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            j_q     <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= 1'b0;
            index_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            j_q     <= j_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            index_q <= index_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Read ports are only driven during their own phase.
    assign rf_addr   = (state_q == S_REGS) ? idx_q : '0;
    assign mem_addr  = (state_q == S_MEM) ? cur_mem_addr : '0;

    assign cpu_halt  = busy_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_tag   = tag_q;
    assign out_index = index_q;

endmodule

// File: tb/tb_state_dump_unit.sv
// -----------------------------------------------------------------------------
// tb_state_dump_unit
//
// Two instances share stimulus: dut0 with default parameters and dut1 with
// register 0 skipped. Register bank reads back 3*i, memory reads back
// 0x100 + address. Accepted beats are collected per instance and compared
// against the expected dump order.
// -----------------------------------------------------------------------------
module tb_state_dump_unit;

    localparam int DW = 32;
    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          start;
    logic          out_ready;
    logic [AW-1:0] mem_base;
    logic [AW:0]   mem_count;

    logic          cpu_halt0, out_valid0, out_tag0, busy0, done0;
    logic [4:0]    rf_addr0;
    logic [AW-1:0] mem_addr0, out_index0;
    logic [DW-1:0] rf_data0, mem_data0, out_data0;

    logic          cpu_halt1, out_valid1, out_tag1, busy1, done1;
    logic [4:0]    rf_addr1;
    logic [AW-1:0] mem_addr1, out_index1;
    logic [DW-1:0] rf_data1, mem_data1, out_data1;

    assign rf_data0  = {27'd0, rf_addr0} * 32'd3;
    assign mem_data0 = 32'h100 + {22'd0, mem_addr0};
    assign rf_data1  = {27'd0, rf_addr1} * 32'd3;
    assign mem_data1 = 32'h100 + {22'd0, mem_addr1};

    state_dump_unit #(.DATA_W(DW), .NREGS(32), .RF_AW(5), .MEM_AW(AW), .SKIP_X0(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .mem_base(mem_base), .mem_count(mem_count),
        .cpu_halt(cpu_halt0), .rf_addr(rf_addr0), .rf_data(rf_data0),
        .mem_addr(mem_addr0), .mem_data(mem_data0),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_tag(out_tag0), .out_index(out_index0), .busy(busy0), .done(done0)
    );

    state_dump_unit #(.DATA_W(DW), .NREGS(32), .RF_AW(5), .MEM_AW(AW), .SKIP_X0(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .mem_base(mem_base), .mem_count(mem_count),
        .cpu_halt(cpu_halt1), .rf_addr(rf_addr1), .rf_data(rf_data1),
        .mem_addr(mem_addr1), .mem_data(mem_data1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .out_tag(out_tag1), .out_index(out_index1), .busy(busy1), .done(done1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_done0  = 0;
    int n_done1  = 0;

    logic [42:0] q0[$];
    logic [42:0] q1[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Beat collector and stall-stability monitor, sampled on the falling edge.
    initial begin
        logic        h0, h1;
        logic [42:0] p0, p1, b0, b1;
        h0 = 1'b0; h1 = 1'b0; p0 = '0; p1 = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                h0 = 1'b0;
                h1 = 1'b0;
            end else begin
                b0 = {out_tag0, out_index0, out_data0};
                b1 = {out_tag1, out_index1, out_data1};
                if (done0) n_done0++;
                if (done1) n_done1++;
                if (h0) begin
                    check("hold_valid0", out_valid0, 1);
                    check("hold_beat0", b0, p0);
                end
                if (h1) begin
                    check("hold_valid1", out_valid1, 1);
                    check("hold_beat1", b1, p1);
                end
                if (out_valid0 && out_ready) q0.push_back(b0);
                if (out_valid1 && out_ready) q1.push_back(b1);
                h0 = out_valid0 && !out_ready;
                h1 = out_valid1 && !out_ready;
                p0 = b0;
                p1 = b1;
            end
        end
    end

    task automatic verify(input int which, input int skip, input int base, input int cnt,
                          input string nm);
        logic [42:0] got[$];
        logic [42:0] exp[$];
        if (which == 0) got = q0;
        else            got = q1;
        for (int i = skip; i < 32; i++) exp.push_back({1'b0, 10'(i), 32'(3 * i)});
        for (int j = 0; j < cnt; j++) begin
            int a;
            a = (base + j) % 1024;
            exp.push_back({1'b1, 10'(a), 32'(32'h100 + a)});
        end
        check({nm, "_len"}, got.size(), exp.size());
        for (int k = 0; k < exp.size() && k < got.size(); k++)
            check($sformatf("%s_beat%0d", nm, k), got[k], exp[k]);
    endtask

    // Called at #1 after a rising edge. mode 1 = ready pattern 1-0-0-1 then random.
    task automatic run_dump(input int base, input int cnt, input int mode, input int restart_at,
                            input string nm);
        int d0, d1, cyc;
        q0.delete();
        q1.delete();
        d0 = n_done0;
        d1 = n_done1;
        mem_base  = AW'(base);
        mem_count = (AW + 1)'(cnt);
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        // Scramble inputs to show they were latched.
        mem_base  = '0;
        mem_count = '0;
        cyc = 0;
        while ((busy0 || busy1) && cyc < 3000) begin
            if (mode == 1)
                out_ready = (cyc < 4) ? (cyc == 0 || cyc == 3) : 1'($urandom_range(0, 1));
            else
                out_ready = 1'b1;
            start = (cyc == restart_at);
            @(posedge clk); #1;
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        check({nm, "_finish"}, cyc < 3000, 1);
        verify(0, 0, base, cnt, {nm, "_d0"});
        verify(1, 1, base, cnt, {nm, "_d1"});
        check({nm, "_done0"}, n_done0 - d0, 1);
        check({nm, "_done1"}, n_done1 - d1, 1);
    endtask

    initial begin
        int d0, d1;
        reset     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        mem_base  = '0;
        mem_count = '0;

        // Reset state
        #12;
        check("rst_valid", out_valid0, 0);
        check("rst_busy", busy0, 0);
        check("rst_halt", cpu_halt0, 0);
        check("rst_done", done0, 0);
        check("rst_tag", out_tag0, 0);
        check("rst_data", out_data0, 0);
        check("rst_index", out_index0, 0);
        check("rst_rfaddr", rf_addr0, 0);
        check("rst_memaddr", mem_addr0, 0);
        check("rst_halt1", cpu_halt1, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", busy0, 0);

        // T1: registers only, full rate, cycle-exact
        q0.delete();
        q1.delete();
        mem_count = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("t1_busy_k", busy0, 1);
        check("t1_halt_k", cpu_halt0, 1);
        check("t1_valid_k", out_valid0, 0);
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            check($sformatf("t1_valid%0d", i), out_valid0, 1);
            check($sformatf("t1_tag%0d", i), out_tag0, 0);
            check($sformatf("t1_index%0d", i), out_index0, i);
            check($sformatf("t1_data%0d", i), out_data0, 3 * i);
        end
        @(posedge clk); #1;
        check("t1_valid_end", out_valid0, 0);
        check("t1_done", done0, 1);
        check("t1_busy_done", busy0, 1);
        check("t1_halt_done", cpu_halt0, 1);
        @(posedge clk); #1;
        check("t1_done_off", done0, 0);
        check("t1_busy_off", busy0, 0);
        check("t1_halt_off", cpu_halt0, 0);
        verify(0, 0, 0, 0, "t1_d0");
        verify(1, 1, 0, 0, "t1_d1");
        check("t1_ndone0", n_done0, 1);
        check("t1_ndone1", n_done1, 1);

        // T2: small memory window
        run_dump(4, 3, 0, -1, "t2");
        // T3: back-pressure
        run_dump(10, 5, 1, -1, "t3");
        // T4: address wrap
        run_dump(1022, 4, 0, -1, "t4");
        // T5: start pulsed mid-dump is ignored
        run_dump(0, 2, 0, 5, "t5");

        // T6: reset during a stall on the 10th beat
        d0 = n_done0;
        d1 = n_done1;
        mem_count = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("t6_index9", out_index0, 9);
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("t6_stall_valid", out_valid0, 1);
        check("t6_stall_index", out_index0, 9);
        #2;
        reset = 1'b0;
        #1;
        check("t6_valid", out_valid0, 0);
        check("t6_busy", busy0, 0);
        check("t6_halt", cpu_halt0, 0);
        check("t6_done", done0, 0);
        check("t6_data", out_data0, 0);
        check("t6_index", out_index0, 0);
        check("t6_tag", out_tag0, 0);
        check("t6_rfaddr", rf_addr0, 0);
        check("t6_busy1", busy1, 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("t6_idle_busy", busy0, 0);
        check("t6_nodone0", n_done0 - d0, 0);
        check("t6_nodone1", n_done1 - d1, 0);
        run_dump(0, 2, 0, -1, "t6b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
